// File: rtl/usb4_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb4_sb_pkg
// Description : Shared types and default timing constants for the USB4
//               sideband line logic (transmit line controller and receive
//               timer).
// Revision    : 1.0 - initial release
// ============================================================================
package usb4_sb_pkg;

    // Encoding is visible on tx_state, so the values are fixed.
    typedef enum logic [1:0] {
        DISC_HOLD  = 2'd0,
        DISC_IDLE  = 2'd1,
        CONNECTING = 2'd2,
        CONNECTED  = 2'd3
    } sb_tx_state_e;

    // Default timing, in sideband clock cycles.
    localparam int unsigned c_tdisconnect_tx_default   = 50;
    localparam int unsigned c_tconnect_tx_default      = 25;
    localparam int unsigned c_tconnect_timeout_default = 500;

endpackage
`default_nettype wire

// File: rtl/sb_tx_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sb_tx_line_ctrl
// Description : Transmit-side sideband line controller for USB4 lane init.
//               Holds SBTX low for a minimum disconnect time, raises it on a
//               connect request and declares link-up once the far end is
//               seen connected. Aborts back to disconnect on timeout.
// Ports       : sb_clk              - sideband clock
//               rst                 - asynchronous reset, active-high
//               disconnect_req      - request/hold disconnect (highest prio)
//               connect_req         - request connect (DISC_IDLE only)
//               sbrx_connected      - far end seen connected
//               sbtx                - registered sideband TX line
//               tx_state            - current state encoding
//               tdisconnect_tx_done - high while in DISC_IDLE
//               link_up             - high while in CONNECTED
//               connect_fail        - one-cycle pulse on CONNECTING timeout
// Revision    : 1.0 - initial release
// ============================================================================
module sb_tx_line_ctrl
    import usb4_sb_pkg::*;
#(
    parameter int unsigned TDISCONNECT_TX   = c_tdisconnect_tx_default,
    parameter int unsigned TCONNECT_TX      = c_tconnect_tx_default,
    parameter int unsigned TCONNECT_TIMEOUT = c_tconnect_timeout_default
) (
    input  logic       sb_clk,
    input  logic       rst,
    input  logic       disconnect_req,
    input  logic       connect_req,
    input  logic       sbrx_connected,
    output logic       sbtx,
    output logic [1:0] tx_state,
    output logic       tdisconnect_tx_done,
    output logic       link_up,
    output logic       connect_fail
);

    localparam int unsigned CNT_W = $clog2(TCONNECT_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] c_disc_last    = CNT_W'(TDISCONNECT_TX - 1);
    localparam logic [CNT_W-1:0] c_conn_min     = CNT_W'(TCONNECT_TX - 1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TCONNECT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_cnt_sat      = '1;

    // Parameter sanity; the last term guards the shared counter being too
    // narrow to reach the disconnect hold terminal count.
    if ((TCONNECT_TIMEOUT <= TCONNECT_TX) || (TDISCONNECT_TX < 2) ||
        (TCONNECT_TX < 1) || (TDISCONNECT_TX > (1 << CNT_W))) begin : g_param_check
        $error("sb_tx_line_ctrl: illegal timing parameters");
    end

    sb_tx_state_e     r_state;
    sb_tx_state_e     w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_timeout;

    logic             r_sbtx;
    logic             r_done;
    logic             r_link;
    logic             r_fail;
    logic             w_sbtx_nxt;
    logic             w_done_nxt;
    logic             w_link_nxt;
    logic             w_fail_nxt;

    // ------------------------------------------------------------------
    // State, counter and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge sb_clk or posedge rst) begin
        if (rst) begin
            r_state <= DISC_HOLD;
            r_cnt   <= '0;
            r_sbtx  <= 1'b0;
            r_done  <= 1'b0;
            r_link  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Shared counter restarts on every state entry. It saturates so
            // long dwell in DISC_IDLE/CONNECTED can never wrap into a
            // spurious terminal count.
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != c_cnt_sat) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_sbtx  <= w_sbtx_nxt;
            r_done  <= w_done_nxt;
            r_link  <= w_link_nxt;
            r_fail  <= w_fail_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        unique case (r_state)
            DISC_HOLD: begin
                // disconnect_req deliberately does not restart the hold.
                if (r_cnt == c_disc_last) begin
                    w_state_nxt = DISC_IDLE;
                end
            end
            DISC_IDLE: begin
                if (connect_req && !disconnect_req) begin
                    w_state_nxt = CONNECTING;
                end
            end
            CONNECTING: begin
                // Qualification is tested before timeout so a coincident
                // far-end connect on the last cycle still brings the link up.
                if (disconnect_req) begin
                    w_state_nxt = DISC_HOLD;
                end else if ((r_cnt >= c_conn_min) && sbrx_connected) begin
                    w_state_nxt = CONNECTED;
                end else if (r_cnt == c_timeout_last) begin
                    w_state_nxt = DISC_HOLD;
                    w_timeout   = 1'b1;
                end
            end
            CONNECTED: begin
                if (disconnect_req || !sbrx_connected) begin
                    w_state_nxt = DISC_HOLD;
                end
            end
            default: w_state_nxt = DISC_HOLD;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state so outputs change on the same edge
    // that enters the new state.
    // ------------------------------------------------------------------
    always_comb begin
        w_sbtx_nxt = (w_state_nxt == CONNECTING) || (w_state_nxt == CONNECTED);
        w_done_nxt = (w_state_nxt == DISC_IDLE);
        w_link_nxt = (w_state_nxt == CONNECTED);
        w_fail_nxt = w_timeout;
    end

    assign sbtx                = r_sbtx;
    assign tx_state            = r_state;
    assign tdisconnect_tx_done = r_done;
    assign link_up             = r_link;
    assign connect_fail        = r_fail;

endmodule
`default_nettype wire
